// File: rtl/qspi_tx_fifo.sv
// qspi_tx_fifo: transmit word buffer for the QSPI controller.
// Words are pushed whole by CSR/DMA and popped one byte at a time, little-endian,
// by the flash FSM. The head byte is presented show-ahead.
//
// Ports:
//   clk          clock, all logic on rising edge
//   reset        synchronous active-high reset
//   flush_i      synchronous clear of contents, pointers and error flags
//   wr_en_i      push request
//   wr_data_i    word to push, byte 0 = bits [7:0]
//   rd_en_i      byte pop request
//   rd_data_o    head byte (8'h00 when empty)
//   last_byte_o  head byte is the final byte of the head word
//   full_o       level_o == DEPTH
//   empty_o      level_o == 0
//   level_o      words held, including a partially consumed head word
//   ovf_o        sticky: push attempted while full
//   udf_o        sticky: pop attempted while empty
module qspi_tx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [7:0]       rd_data_o,
  output logic             last_byte_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [7:0]       level_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned PW    = $clog2(DEPTH);
  // Keep at least one bit of byte index so the WIDTH == 8 case still elaborates.
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [BW-1:0]    byte_idx;
  logic [7:0]       level;
  logic             ovf;
  logic             udf;

  logic             is_full;
  logic             is_empty;
  logic             byte_last;
  logic             push_ok;
  logic             pop_ok;
  logic             word_done;
  logic [WIDTH-1:0] head_word;
  logic [WIDTH-1:0] head_shift;

  always_comb begin
    is_full   = (level == 8'(DEPTH));
    is_empty  = (level == 8'd0);
    byte_last = (byte_idx == BW'(BYTES - 1));
    // Acceptance uses the pre-edge level only, so a freed slot is never reused
    // in the same cycle and a fresh word never passes straight through.
    push_ok   = wr_en_i && !flush_i && !is_full;
    pop_ok    = rd_en_i && !flush_i && !is_empty;
    word_done = pop_ok && byte_last;
  end

  // Storage has no reset; contents are only observable while level is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_idx <= '0;
      level    <= 8'd0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        if (byte_last) begin
          byte_idx <= '0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
      unique case ({push_ok, word_done})
        2'b10:   level <= level + 8'd1;
        2'b01:   level <= level - 8'd1;
        default: level <= level;
      endcase
      if (wr_en_i && is_full) begin
        ovf <= 1'b1;
      end
      if (rd_en_i && is_empty) begin
        udf <= 1'b1;
      end
    end
  end

  always_comb begin
    head_word   = mem[rd_ptr];
    head_shift  = head_word >> {byte_idx, 3'b000};
    rd_data_o   = is_empty ? 8'h00 : head_shift[7:0];
    last_byte_o = !is_empty && byte_last;
    full_o      = is_full;
    empty_o     = is_empty;
    level_o     = level;
    ovf_o       = ovf;
    udf_o       = udf;
  end

endmodule

// File: tb/tb_qspi_tx_fifo.sv
// Directed self-checking bench for qspi_tx_fifo (WIDTH=32, DEPTH=4).
module tb_qspi_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        wr_en_i;
  logic [31:0] wr_data_i;
  logic        rd_en_i;
  logic [7:0]  rd_data_o;
  logic        last_byte_o;
  logic        full_o;
  logic        empty_o;
  logic [7:0]  level_o;
  logic        ovf_o;
  logic        udf_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qspi_tx_fifo #(
    .WIDTH(32),
    .DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .last_byte_o(last_byte_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .ovf_o      (ovf_o),
    .udf_o      (udf_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    wr_en_i   = 1'b1;
    wr_data_i = w;
    step();
    wr_en_i   = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  // Pop n bytes, expecting first, first+1, ...; last_byte expected every 4th.
  task automatic pop_seq(input string tag, input int n, input logic [7:0] first,
                         input int start_idx);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_data"}, 32'(rd_data_o), 32'(first + 8'(i)));
      check_eq({tag, "_last"}, 32'(last_byte_o), 32'(((start_idx + i) % 4) == 3));
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_empty"}, 32'(empty_o), 32'd1);
    check_eq({tag, "_full"},  32'(full_o), 32'd0);
    check_eq({tag, "_level"}, 32'(level_o), 32'd0);
    check_eq({tag, "_data"},  32'(rd_data_o), 32'd0);
    check_eq({tag, "_last"},  32'(last_byte_o), 32'd0);
    check_eq({tag, "_ovf"},   32'(ovf_o), 32'd0);
    check_eq({tag, "_udf"},   32'(udf_o), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    flush_i   = 1'b0;
    wr_en_i   = 1'b0;
    wr_data_i = 32'h0;
    rd_en_i   = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check_idle("rst");

    // Fill to full.
    push(32'h03020100);
    check_eq("lvl1", 32'(level_o), 32'd1);
    check_eq("data_after_push", 32'(rd_data_o), 32'h00);
    push(32'h07060504);
    push(32'h0B0A0908);
    push(32'h0F0E0D0C);
    check_eq("full", 32'(full_o), 32'd1);
    check_eq("lvl4", 32'(level_o), 32'd4);

    // Overflow attempt.
    push(32'hDEADBEEF);
    check_eq("ovf_set", 32'(ovf_o), 32'd1);
    check_eq("ovf_lvl", 32'(level_o), 32'd4);

    // Drain 16 bytes back-to-back.
    rd_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_data",  32'(rd_data_o), 32'(i));
      check_eq("drain_last",  32'(last_byte_o), 32'((i % 4) == 3));
      check_eq("drain_level", 32'(level_o), 32'(4 - i / 4));
      step();
    end
    rd_en_i = 1'b0;
    check_eq("drain_empty", 32'(empty_o), 32'd1);
    check_eq("drain_lvl0",  32'(level_o), 32'd0);
    check_eq("ovf_sticky",  32'(ovf_o), 32'd1);
    do_flush();
    check_eq("ovf_flushed", 32'(ovf_o), 32'd0);

    // Underflow.
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    check_eq("udf_set",   32'(udf_o), 32'd1);
    check_eq("udf_empty", 32'(empty_o), 32'd1);
    check_eq("udf_data",  32'(rd_data_o), 32'd0);
    check_eq("udf_lvl",   32'(level_o), 32'd0);
    step();
    check_eq("udf_sticky", 32'(udf_o), 32'd1);
    do_flush();
    check_idle("flush1");

    // Push+pop at level 2, byte index 3.
    push(32'h13121110);
    push(32'h17161514);
    pop_seq("sim1a", 3, 8'h10, 0);
    check_eq("sim1_pre_lvl", 32'(level_o), 32'd2);
    check_eq("sim1_pre_data", 32'(rd_data_o), 32'h13);
    wr_en_i   = 1'b1;
    wr_data_i = 32'h1B1A1918;
    rd_en_i   = 1'b1;
    step();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    check_eq("sim1_lvl", 32'(level_o), 32'd2);
    pop_seq("sim1b", 8, 8'h14, 0);
    check_eq("sim1_empty", 32'(empty_o), 32'd1);

    // Push+pop at level 4, byte index 3: pop wins, push rejected.
    push(32'h23222120);
    push(32'h27262524);
    push(32'h2B2A2928);
    push(32'h2F2E2D2C);
    pop_seq("sim2a", 3, 8'h20, 0);
    wr_en_i   = 1'b1;
    wr_data_i = 32'hDEADBEEF;
    rd_en_i   = 1'b1;
    step();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    check_eq("sim2_ovf",  32'(ovf_o), 32'd1);
    check_eq("sim2_lvl",  32'(level_o), 32'd3);
    check_eq("sim2_full", 32'(full_o), 32'd0);
    pop_seq("sim2b", 12, 8'h24, 0);
    check_eq("sim2_empty", 32'(empty_o), 32'd1);
    do_flush();

    // Flush mid-word with a simultaneous push.
    push(32'hAABBCCDD);
    check_eq("fl_b0", 32'(rd_data_o), 32'hDD);
    rd_en_i = 1'b1;
    step();
    check_eq("fl_b1", 32'(rd_data_o), 32'hCC);
    step();
    rd_en_i   = 1'b0;
    check_eq("fl_b2", 32'(rd_data_o), 32'hBB);
    flush_i   = 1'b1;
    wr_en_i   = 1'b1;
    wr_data_i = 32'h55555555;
    step();
    flush_i = 1'b0;
    wr_en_i = 1'b0;
    check_idle("flush2");
    push(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      check_eq("post_flush_data", 32'(rd_data_o), 32'(8'h11 * (i + 1)));
      check_eq("post_flush_last", 32'(last_byte_o), 32'(i == 3));
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
    end
    check_eq("post_flush_empty", 32'(empty_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qspi_tx_fifo.md
# qspi_tx_fifo

Transmit-side data buffer for the QSPI controller. CSR/DMA pushes full words. The flash FSM pops them one byte at a time, in address order, to feed the IO shifter during page-program and write-register data phases. It complements the RX FIFO, which sits on the opposite data path. It adds byte unpacking, a flush, and sticky overflow/underflow flags.

## Interface
- WIDTH, 32: word width in bits; must be a multiple of 8, ≥ 8.
- DEPTH, 4: word capacity; power of two, 2..128.

- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous clear of contents, pointers and error flags.
- wr_en_i  input  1  push request from CSR/DMA.
- wr_data_i  input  WIDTH  word to push; byte 0 = bits [7:0].
- rd_en_i  input  1  byte pop request from FSM.
- rd_data_o  output  8  current head byte (show-ahead).
- last_byte_o  output  1  head byte is the final byte of the head word.
- full_o  output  1  level_o == DEPTH.
- empty_o  output  1  level_o == 0.
- level_o  output  8  words held; a partially consumed head word still counts.
- ovf_o  output  1  sticky: push attempted while full.
- udf_o  output  1  sticky: pop attempted while empty.

## Operation
- Storage: DEPTH × WIDTH array, write pointer, read pointer (log2(DEPTH) bits, natural wrap), byte index (log2(WIDTH/8) bits), level counter.
- A push is accepted iff wr_en_i=1, flush_i=0 and level_o<DEPTH, sampled before the edge.
  - Accepted: data written at the write pointer, write pointer +1.
  - Rejected when full: ovf_o set. Nothing else changes.
- A pop is accepted iff rd_en_i=1, flush_i=0 and level_o>0.
  - If byte index < WIDTH/8−1: byte index +1.
  - Otherwise: byte index → 0, read pointer +1, and the word leaves.
  - Rejected when empty: udf_o set.
- Level update per edge: +1 on an accepted push; −1 on an accepted pop that completes a word; both or neither → unchanged.
- Pushes and pops never share a freed slot in the same cycle.
  - A push while full is rejected even if a simultaneous pop completes the head word.
  - A pop while empty is rejected even if a simultaneous push is accepted. No pass-through.
- rd_data_o = byte [8·idx+7 : 8·idx] of the word at the read pointer when empty_o=0; 8'h00 when empty.
- last_byte_o = !empty_o && (byte index == WIDTH/8−1).
- Byte order is little-endian: wr_data_i 32'h03020100 is emitted as 00, 01, 02, 03.
- Flush is identical in effect to reset and has priority over same-cycle push/pop. A push dropped by flush does not set ovf_o.
- ovf_o and udf_o clear only on reset or flush.

## Timing
- Reset values: rd_data_o=0, last_byte_o=0, full_o=0, empty_o=1, level_o=0, ovf_o=0, udf_o=0. Pointers and byte index = 0. Array contents need no reset.
- All outputs are functions of registered state only; no combinational path from any input to any output.
- Push latency: a word pushed at edge N appears on rd_data_o/level_o after edge N (visible in cycle N+1).
- Pop: rd_data_o advances to the next byte after the accepting edge. The FSM may hold rd_en_i high for back-to-back bytes at one byte per clock.
- Full-speed sustained flow at 1 word per WIDTH/8 clocks is possible at any level between 1 and DEPTH−1.
- Reset or flush asserted mid-word discards the partial head word. The next pushed word is emitted from byte 0.

## Test plan
- Reset, then idle 3 cycles → empty_o=1, full_o=0, level_o=0, rd_data_o=8'h00, last_byte_o=0, ovf_o=udf_o=0.
- Push 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C back-to-back → full_o=1, level_o=4. Then hold rd_en_i 16 cycles:
  - rd_data_o = 8'h00..8'h0F in order;
  - last_byte_o high on bytes 03, 07, 0B, 0F;
  - level_o steps 4→3→2→1→0; empty_o=1 at the end.
- Overflow: with FIFO full, push 32'hDEADBEEF → ovf_o=1, level_o stays 4, popped data unchanged (00..0F). ovf_o remains 1 until flush.
- Underflow: rd_en_i on an empty FIFO → udf_o=1, empty_o stays 1, rd_data_o=8'h00, level_o=0.
- Simultaneous events:
  - level_o=2, byte index=3: push + pop in the same cycle → level_o stays 2, next rd_data_o = byte 0 of the second word.
  - level_o=4, byte index=3: push + pop → pop accepted, push rejected, ovf_o=1, level_o=3.
- Flush mid-word: after 2 bytes of 32'hAABBCCDD are popped, assert flush_i together with wr_en_i → empty_o=1, level_o=0, flags 0. A later push of 32'h44332211 is emitted as 11, 22, 33, 44.
